// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: operand forwarding
// select encodings and small helpers used by the top and the scoreboard.
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] FWD_REG    = 2'd0;
    localparam logic [1:0] FWD_M_ALU  = 2'd1;
    localparam logic [1:0] FWD_M_LOAD = 2'd2;
    localparam logic [1:0] FWD_WB     = 2'd3;

    // M beats WB; a load sitting in M is only usable when the memory answers
    // in the same cycle, otherwise the interlock has already kept it out.
    function automatic logic [1:0] fwd_select(
        input logic hit_m,
        input logic m_is_load,
        input logic load_fwd,
        input logic hit_wb
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (hit_m) begin
            if (m_is_load) begin
                sel = load_fwd ? FWD_M_LOAD : FWD_REG;
            end else begin
                sel = FWD_M_ALU;
            end
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_mc_scoreboard.sv
// Multi-cycle unit tracker: latency countdown, destination register and the
// per-register pending vector that the ID hazard logic consults.
module mc_scoreboard
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_issue,
    input  logic [REG_AW-1:0]      i_issue_wa,
    input  logic                   i_issue_we,
    output logic [2**REG_AW-1:0]   o_pending,
    output logic [REG_AW-1:0]      o_wa,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int CNT_W = cnt_width(MC_LAT);
    localparam int NREG  = 2 ** REG_AW;

    logic [CNT_W-1:0]  r_cnt;
    logic [NREG-1:0]   r_pending;
    logic [REG_AW-1:0] r_wa;

    logic w_busy;
    logic w_done;
    logic w_set;

    assign w_busy = (r_cnt != '0);
    assign w_done = (r_cnt == CNT_W'(1));
    assign w_set  = i_issue && i_issue_we && (i_issue_wa != '0);

    // Issue is blocked while busy, so a set never lands on the done edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_pending <= '0;
            r_wa      <= '0;
        end else begin
            if (i_issue) begin
                r_cnt <= CNT_W'(MC_LAT);
                r_wa  <= i_issue_wa;
            end else if (w_busy) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_done) begin
                r_pending[r_wa] <= 1'b0;
            end
            if (w_set) begin
                r_pending[i_issue_wa] <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_wa      = r_wa;
    assign o_busy    = w_busy;
    assign o_done    = w_done;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding selects, ID-stage interlock and multi-cycle issue control for the
// 5-stage pipeline, plus a saturating count of stalled cycles.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int LOAD_IN_M = 1,
    parameter int MC_LAT    = 4,
    parameter int PERF_W    = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [REG_AW-1:0] ID_RA1,
    input  logic [REG_AW-1:0] ID_RA2,
    input  logic              ID_RE1,
    input  logic              ID_RE2,
    input  logic [REG_AW-1:0] ID_REG_WA,
    input  logic              ID_REG_WE,
    input  logic              ID_isMC,
    input  logic              Flush,
    input  logic [REG_AW-1:0] EX_REG_RA1,
    input  logic [REG_AW-1:0] EX_REG_RA2,
    input  logic              EX_RE1,
    input  logic              EX_RE2,
    input  logic [REG_AW-1:0] EX_REG_WA,
    input  logic              EX_REG_WE,
    input  logic              EX_isLoad,
    input  logic [REG_AW-1:0] M_REG_WA,
    input  logic              M_REG_WE,
    input  logic              M_isLoad,
    input  logic [REG_AW-1:0] WB_REG_WA,
    input  logic              WB_REG_WE,
    output logic [1:0]        RegVal1Select,
    output logic [1:0]        RegVal2Select,
    output logic              ID_Stall,
    output logic              EX_Bubble,
    output logic              MC_Start,
    output logic              MC_Done,
    output logic [REG_AW-1:0] MC_WA,
    output logic              MC_Busy,
    output logic [PERF_W-1:0] StallCount
);

    localparam int   NREG     = 2 ** REG_AW;
    localparam logic LOAD_FWD = (LOAD_IN_M != 0);

    logic [NREG-1:0]   w_pending;
    logic [REG_AW-1:0] w_mc_wa;
    logic              w_mc_busy;
    logic              w_mc_done;

    logic w_ex1_m, w_ex1_wb, w_ex2_m, w_ex2_wb;
    logic w_src1, w_src2;
    logic w_lu, w_raw, w_waw, w_str;
    logic w_stall, w_issue;

    logic [PERF_W-1:0] r_stall_cnt;

    // EX operand forwarding
    assign w_ex1_m  = EX_RE1 && (EX_REG_RA1 != '0) && M_REG_WE  && (EX_REG_RA1 == M_REG_WA);
    assign w_ex1_wb = EX_RE1 && (EX_REG_RA1 != '0) && WB_REG_WE && (EX_REG_RA1 == WB_REG_WA);
    assign w_ex2_m  = EX_RE2 && (EX_REG_RA2 != '0) && M_REG_WE  && (EX_REG_RA2 == M_REG_WA);
    assign w_ex2_wb = EX_RE2 && (EX_REG_RA2 != '0) && WB_REG_WE && (EX_REG_RA2 == WB_REG_WA);

    assign RegVal1Select = fwd_select(w_ex1_m, M_isLoad, LOAD_FWD, w_ex1_wb);
    assign RegVal2Select = fwd_select(w_ex2_m, M_isLoad, LOAD_FWD, w_ex2_wb);

    // ID hazards; register 0 reads never create a dependency
    assign w_src1 = ID_RE1 && (ID_RA1 != '0);
    assign w_src2 = ID_RE2 && (ID_RA2 != '0);

    assign w_lu  = !LOAD_FWD && EX_isLoad && EX_REG_WE &&
                   ((w_src1 && (ID_RA1 == EX_REG_WA)) ||
                    (w_src2 && (ID_RA2 == EX_REG_WA)));
    assign w_raw = (w_src1 && w_pending[ID_RA1]) ||
                   (w_src2 && w_pending[ID_RA2]);
    assign w_waw = ID_REG_WE && w_pending[ID_REG_WA];
    assign w_str = ID_isMC && w_mc_busy;

    // Gated by RSTn so the interlock and issue pulse are quiet during reset.
    assign w_stall = RSTn && !Flush && (w_lu || w_raw || w_waw || w_str);
    assign w_issue = RSTn && !Flush && ID_isMC && !w_stall;

    assign ID_Stall  = w_stall;
    assign EX_Bubble = w_stall;
    assign MC_Start  = w_issue;

    mc_scoreboard #(
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT)
    ) u_mc_scoreboard (
        .i_clk      (CLK),
        .i_rst_n    (RSTn),
        .i_issue    (w_issue),
        .i_issue_wa (ID_REG_WA),
        .i_issue_we (ID_REG_WE),
        .o_pending  (w_pending),
        .o_wa       (w_mc_wa),
        .o_busy     (w_mc_busy),
        .o_done     (w_mc_done)
    );

    assign MC_WA   = w_mc_wa;
    assign MC_Busy = w_mc_busy;
    assign MC_Done = w_mc_done;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign StallCount = r_stall_cnt;

endmodule
